rpn_sequencer: RTL and testbench
================================

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter data_width, default 4, operand and result width.
REQ-002 Parameter STACK_depth, default 32, calculator stack capacity in entries.
REQ-003 Parameter push_cycles, default 2, calculator busy cycles after a push pulse.
REQ-004 Parameter op_cycles, default 4, calculator busy cycles after a func pulse.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 clear  input  1  synchronous flush of the FIFO, depth and error flags.
REQ-008 tok_valid  input  1  token offered.
REQ-009 tok_ready  output  1  token accepted when tok_valid and tok_ready are both high.
REQ-010 tok_is_op  input  1  1 = operator token, 0 = operand token.
REQ-011 tok_data  input  data_width  operand value; bits [1:0] hold the ALU opcode for operator tokens.
REQ-012 push  output  1  one-cycle push pulse to the calculator.
REQ-013 func  output  1  one-cycle operate pulse to the calculator.
REQ-014 ALU_opcode  output  2  opcode presented to the calculator, held stable from the pulse to the end of the busy window.
REQ-015 dataIn  output  data_width  operand presented to the calculator, held stable from the pulse to the end of the busy window.
REQ-016 calc_dataOut  input  data_width  calculator result register.
REQ-017 result  output  data_width  captured result.
REQ-018 result_valid  output  1  one-cycle pulse marking a new result.
REQ-019 depth  output  6  tracked calculator stack occupancy.
REQ-020 busy  output  1  high in any state other than IDLE, or when the FIFO is non-empty.
REQ-021 err_underflow  output  1  sticky flag: operator issued with depth < 2.
REQ-022 err_overflow  output  1  sticky flag: operand issued with depth == STACK_depth.

Function
REQ-023 Tokens SHALL enter a 4-entry FIFO; tok_ready = FIFO not full; a write while full is ignored; there is no write-through.
REQ-024 The FSM SHALL have states IDLE, LOAD, ISSUE and WAIT.
- IDLE -> LOAD when the FIFO is non-empty.
- LOAD: pop the head into the holding register, then go to ISSUE.
- ISSUE: emit the pulse, then go to WAIT.
- WAIT: count down, then return to IDLE.
REQ-025 ISSUE with an operand and depth < STACK_depth SHALL assert push for exactly one cycle, set dataIn = operand, and increment depth.
REQ-026 ISSUE with an operator and depth >= 2 SHALL assert func for exactly one cycle, set ALU_opcode = tok_data[1:0], and decrement depth by 1.
REQ-027 An operand issued at depth == STACK_depth SHALL be dropped: no push pulse, err_overflow set, FSM returns directly to IDLE.
REQ-028 An operator issued at depth < 2 SHALL be dropped: no func pulse, err_underflow set, FSM returns directly to IDLE.
REQ-029 WAIT SHALL last push_cycles cycles after a push or op_cycles cycles after a func; no second pulse may occur inside that window.
REQ-030 On exit from WAIT after a func, result SHALL capture calc_dataOut and result_valid SHALL pulse for one cycle.
REQ-031 End-to-end latency SHALL be fixed:
- Operand: pulse 2 cycles after FIFO non-empty in IDLE; next token pulse no earlier than push_cycles+3 cycles later.
- Operator: result_valid op_cycles+1 cycles after the func pulse.
REQ-032 depth SHALL saturate within 0..STACK_depth and never wrap.
REQ-033 clear SHALL take priority over a token write in the same cycle.
- In IDLE, LOAD or ISSUE: zero FIFO, depth and error flags; return to IDLE; suppress any pulse in that cycle.
- In WAIT: finish the current window, then flush.

Reset
REQ-034 rst_n low at a clock edge SHALL force IDLE, empty the FIFO, and set every output to 0, with tok_ready = 0 during reset and 1 on the first cycle after release.
REQ-035 Reset mid-WAIT SHALL abandon the window immediately, with no result_valid pulse.

Structure
REQ-036 A shared header rpn_pkg SHALL hold the FSM state encodings, the ALU opcode constants (ADD, SUB, AND, OR) and the FIFO depth constant.
REQ-037 The FIFO SHALL be a separate sub-module, token_fifo, parameterised by width (data_width+1) and depth 4.

Verification
REQ-038 Push 3, push 5, op ADD with calc_dataOut model = 8 -> push pulses with dataIn 3 then 5, depth 1 then 2, func with ALU_opcode 0, depth 1, result = 8 with a single result_valid.
REQ-039 Op token at depth 1 -> no func pulse, err_underflow = 1, depth stays 1, next operand still issues.
REQ-040 Issue 32 operands, then a 33rd -> 32 push pulses, 33rd dropped, err_overflow = 1, depth = 32.
REQ-041 Offer 6 back-to-back tokens while the sequencer is stalled in WAIT -> tok_ready low after 4 accepts; no token lost or duplicated; issue order preserved.
REQ-042 rst_n low during the op WAIT window, and separately clear high in IDLE with 2 tokens queued -> all outputs 0, no result_valid, depth = 0, FIFO empty.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN token sequencer: FSM states, ALU opcodes, FIFO depth.
package rpn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/token_fifo.sv
// Small synchronous token FIFO; head is visible combinationally, no write-through.
module token_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        do_wr, do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    do_wr  = wr_en && !full;
    do_rd  = rd_en && !empty;
    if (do_wr) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_rd) rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Feeds queued RPN tokens to a multi-cycle stack calculator, tracking stack depth
// and capturing the calculator result after each operator.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int data_width  = 4,
  parameter int STACK_depth = 32,
  parameter int push_cycles = 2,
  parameter int op_cycles   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [data_width-1:0] tok_data,
  output logic                  push,
  output logic                  func,
  output logic [1:0]            ALU_opcode,
  output logic [data_width-1:0] dataIn,
  input  logic [data_width-1:0] calc_dataOut,
  output logic [data_width-1:0] result,
  output logic                  result_valid,
  output logic [5:0]            depth,
  output logic                  busy,
  output logic                  err_underflow,
  output logic                  err_overflow
);
  localparam int TW   = data_width + 1;
  localparam int MAXC = (push_cycles > op_cycles) ? push_cycles : op_cycles;
  localparam int CW   = $clog2(MAXC + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [5:0]            depth_q, depth_d;
  logic                  op_q, op_d;
  logic                  was_func_q, was_func_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  err_un_q, err_un_d, err_ov_q, err_ov_d;
  logic [1:0]            alu_q, alu_d;
  logic [data_width-1:0] din_q, din_d, res_q, res_d;
  logic                  rv_q, rv_d;
  logic                  push_w, func_w, pop, flush;
  logic                  fifo_full, fifo_empty, wr_en;
  logic [TW-1:0]         head;

  assign tok_ready = rst_n && !fifo_full;
  assign wr_en     = tok_valid && tok_ready && !clear;

  token_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data ({tok_is_op, tok_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    depth_d    = depth_q;
    op_d       = op_q;
    was_func_d = was_func_q;
    clr_pend_d = clr_pend_q;
    err_un_d   = err_un_q;
    err_ov_d   = err_ov_q;
    alu_d      = alu_q;
    din_d      = din_q;
    res_d      = res_q;
    rv_d       = 1'b0;
    push_w     = 1'b0;
    func_w     = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    // Outside WAIT a clear takes effect at once and wipes the presented values.
    if (clear && state_q != S_WAIT) begin
      state_d    = S_IDLE;
      flush      = 1'b1;
      depth_d    = '0;
      err_un_d   = 1'b0;
      err_ov_d   = 1'b0;
      clr_pend_d = 1'b0;
      alu_d      = '0;
      din_d      = '0;
      res_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) state_d = S_LOAD;
        S_LOAD: begin
          pop     = 1'b1;
          op_d    = head[data_width];
          if (head[data_width]) alu_d = head[1:0];
          else                  din_d = head[data_width-1:0];
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          state_d = S_IDLE;
          if (!op_q) begin
            if (depth_q < 6'(STACK_depth)) begin
              push_w     = 1'b1;
              depth_d    = depth_q + 6'd1;
              cnt_d      = CW'(push_cycles - 1);
              was_func_d = 1'b0;
              state_d    = S_WAIT;
            end else begin
              err_ov_d = 1'b1;
            end
          end else if (depth_q >= 6'd2) begin
            func_w     = 1'b1;
            depth_d    = depth_q - 6'd1;
            cnt_d      = CW'(op_cycles - 1);
            was_func_d = 1'b1;
            state_d    = S_WAIT;
          end else begin
            err_un_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (clear) clr_pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            if (was_func_q) begin
              res_d = calc_dataOut;
              rv_d  = 1'b1;
            end
            // A clear seen during the window lands here, keeping the captured result.
            if (clr_pend_q || clear) begin
              flush      = 1'b1;
              depth_d    = '0;
              err_un_d   = 1'b0;
              err_ov_d   = 1'b0;
              clr_pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      depth_q    <= '0;
      op_q       <= 1'b0;
      was_func_q <= 1'b0;
      clr_pend_q <= 1'b0;
      err_un_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      alu_q      <= '0;
      din_q      <= '0;
      res_q      <= '0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      depth_q    <= depth_d;
      op_q       <= op_d;
      was_func_q <= was_func_d;
      clr_pend_q <= clr_pend_d;
      err_un_q   <= err_un_d;
      err_ov_q   <= err_ov_d;
      alu_q      <= alu_d;
      din_q      <= din_d;
      res_q      <= res_d;
      rv_q       <= rv_d;
    end
  end

  assign push          = rst_n && push_w;
  assign func          = rst_n && func_w;
  assign busy          = rst_n && ((state_q != S_IDLE) || !fifo_empty);
  assign ALU_opcode    = alu_q;
  assign dataIn        = din_q;
  assign result        = res_q;
  assign result_valid  = rv_q;
  assign depth         = depth_q;
  assign err_underflow = err_un_q;
  assign err_overflow  = err_ov_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer with a behavioural stack calculator attached.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clear, tok_valid, tok_is_op;
  logic       tok_ready, push, func, result_valid, busy, err_underflow, err_overflow;
  logic [3:0] tok_data, dataIn, calc_dataOut, result;
  logic [1:0] ALU_opcode;
  logic [5:0] depth;

  rpn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .push(push), .func(func),
    .ALU_opcode(ALU_opcode), .dataIn(dataIn), .calc_dataOut(calc_dataOut),
    .result(result), .result_valid(result_valid), .depth(depth), .busy(busy),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_op; int val; int dep;} exp_t;
  exp_t       expq[$];
  int         rq[$];
  logic [3:0] mstk[$];
  logic [3:0] cstk[$];
  logic [3:0] ea, eb;
  bit         mun, mov;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_pulse = 0, func_cyc = 0, n_push = 0, n_func = 0, n_rv = 0, dchk_val = 0;
  bit have_last = 0, last_was_func = 0, dchk_pend = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Calculator environment: reacts to the DUT pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (push) cstk.push_back(dataIn);
    else if (func && cstk.size() >= 2) begin
      eb = cstk.pop_back();
      ea = cstk.pop_back();
      cstk.push_back(alu(ea, eb, ALU_opcode));
    end
    calc_dataOut <= (cstk.size() > 0) ? cstk[cstk.size()-1] : 4'd0;
  end

  // Output monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (dchk_pend) begin
        chk("depth_after", depth, dchk_val);
        dchk_pend = 0;
      end
      if (push || func) begin
        if (push) n_push++;
        if (func) n_func++;
        if (expq.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = expq.pop_front();
          chk("pulse_kind", func, e.is_op);
          if (e.is_op) chk("alu_opcode", ALU_opcode, e.val);
          else         chk("data_in", dataIn, e.val);
          chk("depth_pre", depth, e.dep);
          dchk_pend = 1;
          dchk_val  = e.is_op ? e.dep - 1 : e.dep + 1;
        end
        if (have_last) chk("pulse_gap", (cyc - last_pulse) >= (last_was_func ? 7 : 5), 1);
        have_last = 1; last_pulse = cyc; last_was_func = func;
        if (func) func_cyc = cyc;
      end
      if (result_valid) begin
        n_rv++;
        chk("rv_latency", cyc - func_cyc, 5);
        if (rq.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result", result, rq.pop_front());
      end
    end
  end

  task automatic model_tok(input bit op, input logic [3:0] d);
    exp_t e;
    logic [3:0] a, b, r;
    if (!op) begin
      if (mstk.size() < 32) begin
        e.is_op = 0; e.val = d; e.dep = mstk.size();
        expq.push_back(e); mstk.push_back(d);
      end else mov = 1;
    end else begin
      if (mstk.size() >= 2) begin
        e.is_op = 1; e.val = d[1:0]; e.dep = mstk.size();
        expq.push_back(e);
        b = mstk.pop_back(); a = mstk.pop_back();
        r = alu(a, b, d[1:0]);
        mstk.push_back(r); rq.push_back(r);
      end else mun = 1;
    end
  endtask

  task automatic model_clear();
    expq.delete(); rq.delete(); mstk.delete(); cstk.delete();
    mun = 0; mov = 0; have_last = 0; dchk_pend = 0;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Caller must be 1 time unit after a rising edge; returns likewise.
  task automatic send(input bit op, input logic [3:0] d, output int waited);
    bit acc;
    model_tok(op, d);
    tok_valid = 1'b1; tok_is_op = op; tok_data = d; waited = 0; acc = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk); acc = tok_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    tok_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_pulse(input bit want_func);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = want_func ? func : push;
    end
    chk(want_func ? "func_seen" : "push_seen", seen, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (3) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  task automatic chk_quiet();
    chk("q_push", push, 0);           chk("q_func", func, 0);
    chk("q_result_valid", result_valid, 0);
    chk("q_depth", depth, 0);         chk("q_busy", busy, 0);
    chk("q_err_underflow", err_underflow, 0);
    chk("q_err_overflow", err_overflow, 0);
    chk("q_result", result, 0);       chk("q_data_in", dataIn, 0);
    chk("q_alu_opcode", ALU_opcode, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    int ws[6];
    int snap, streak;
    bit stalled;
    rst_n = 1'b0; clear = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tok_ready", tok_ready, 0);
    chk_quiet();
    align(); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", tok_ready, 1);

    // Basic push, push, add.
    align();
    send(0, 4'd3, w); send(0, 4'd5, w); send(1, ALU_ADD, w);
    wait_idle();
    chk("depth_basic", depth, 1);
    chk("rv_count_basic", n_rv, 1);

    // Operator at depth 1 is dropped, later operands still issue.
    align(); send(1, ALU_SUB, w);
    wait_idle();
    chk("underflow_flag", err_underflow, 1);
    chk("depth_after_underflow", depth, 1);
    chk("overflow_flag_clear", err_overflow, 0);
    align();
    send(0, 4'd7, w); send(1, ALU_SUB, w);
    send(0, 4'd6, w); send(1, ALU_OR, w);
    send(0, 4'd12, w); send(1, ALU_AND, w);
    wait_idle();
    chk("depth_mix", depth, mstk.size());

    // Reset in the middle of an operator window.
    align(); send(0, 4'd2, w); send(1, ALU_ADD, w);
    wait_pulse(1);
    align(); align();
    rst_n = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", tok_ready, 0);
    align(); rst_n = 1'b1;
    model_clear();
    snap = n_rv;
    @(negedge clk);
    chk("ready_after_midreset", tok_ready, 1);
    chk_quiet();
    repeat (10) @(negedge clk);
    chk("no_rv_after_reset", n_rv - snap, 0);

    // Fill the stack and overflow it.
    snap = n_push;
    align();
    for (int i = 0; i < 33; i++) send(0, 4'(i), w);
    wait_idle();
    chk("overflow_pushes", n_push - snap, 32);
    chk("overflow_flag", err_overflow, 1);
    chk("depth_full", depth, 32);

    // Back-to-back tokens while stalled in an operator window.
    align(); send(1, ALU_ADD, w);
    wait_pulse(1);
    align();
    send(1, ALU_ADD, ws[0]); send(0, 4'd9, ws[1]); send(0, 4'd10, ws[2]);
    send(1, ALU_SUB, ws[3]); send(0, 4'd11, ws[4]); send(1, ALU_OR, ws[5]);
    streak = 0; stalled = 0;
    foreach (ws[i]) begin
      if (ws[i] != 0) stalled = 1;
      if (!stalled) streak++;
    end
    chk("accepts_before_stall", streak, 4);
    chk("fifth_token_stalled", ws[4] > 0, 1);
    wait_idle();
    chk("depth_burst", depth, mstk.size());

    // Clear in IDLE with two tokens queued.
    align(); send(0, 4'd9, w);
    wait_pulse(0);
    align(); tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 4'd1;
    @(negedge clk); chk("clr_ready_a", tok_ready, 1);
    align(); tok_data = 4'd2;
    @(negedge clk); chk("clr_ready_b", tok_ready, 1);
    align(); tok_valid = 1'b0; clear = 1'b1;
    @(negedge clk); chk("clr_no_push", push, 0);
    align(); clear = 1'b0;
    model_clear();
    snap = n_push + n_func;
    @(negedge clk);
    chk_quiet();
    chk("clr_ready", tok_ready, 1);
    repeat (10) @(negedge clk);
    chk("clr_no_pulses", n_push + n_func - snap, 0);
    chk("clr_busy", busy, 0);

    chk("expq_drained", expq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
